// File: rtl/crc32_pkg.sv
// Shared CRC-32 constants and frame serializer state encoding.
package crc32_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAD  = 2'd2,
        ST_FCS  = 2'd3
    } ser_state_t;

endpackage

// File: rtl/crc32_lfsr.sv
// Serial CRC-32 LFSR core: q[31] feedback, all-ones load on init, one data bit per enabled edge.
module crc32_lfsr
    import crc32_pkg::*;
(
    input  logic        clk,
    input  logic        init,
    input  logic        en,
    input  logic        d,
    output logic [31:0] q
);

    always_ff @(posedge clk) begin
        if (init) begin
            q <= CRC32_INIT;
        end else if (en) begin
            q <= {q[30:0], 1'b0} ^ ({32{q[31] ^ d}} & CRC32_POLY);
        end
    end

endmodule

// File: rtl/crc32_frame_serializer.sv
// Byte-to-bit frame serializer: LSB-first data, optional zero padding, complemented CRC-32 FCS.
module crc32_frame_serializer
    import crc32_pkg::*;
#(
    parameter int unsigned MIN_BYTES = 60,
    parameter int unsigned CNT_W     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic        tx_valid,
    output logic        tx_bit,
    output logic        tx_last,
    input  logic        tx_ready,
    output logic        crc_init,
    output logic        crc_en,
    output logic        crc_d,
    input  logic [31:0] crc_q
);

    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_BYTES);

    ser_state_t       state, state_nxt;
    logic [7:0]       byte_q, byte_nxt;
    logic             last_q, last_nxt;
    logic [2:0]       bit_idx, bit_nxt;
    logic [4:0]       fcs_idx, fcs_nxt;
    logic [CNT_W-1:0] byte_cnt, cnt_nxt;
    logic             underrun, underrun_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic [4:0]       fcs_sel;

    assign cnt_inc = (&byte_cnt) ? byte_cnt : byte_cnt + CNT_W'(1);
    assign fcs_sel = 5'd31 - fcs_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            byte_q   <= 8'h00;
            last_q   <= 1'b0;
            bit_idx  <= 3'd0;
            fcs_idx  <= 5'd0;
            byte_cnt <= '0;
            underrun <= 1'b0;
        end else begin
            state    <= state_nxt;
            byte_q   <= byte_nxt;
            last_q   <= last_nxt;
            bit_idx  <= bit_nxt;
            fcs_idx  <= fcs_nxt;
            byte_cnt <= cnt_nxt;
            underrun <= underrun_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        byte_nxt     = byte_q;
        last_nxt     = last_q;
        bit_nxt      = bit_idx;
        fcs_nxt      = fcs_idx;
        cnt_nxt      = byte_cnt;
        underrun_nxt = underrun;
        s_ready      = 1'b0;
        tx_valid     = 1'b0;
        tx_bit       = 1'b0;
        tx_last      = 1'b0;
        crc_init     = 1'b0;
        crc_en       = 1'b0;
        crc_d        = 1'b0;

        case (state)
            ST_IDLE: begin
                s_ready  = 1'b1;
                crc_init = 1'b1;
                if (s_valid) begin
                    byte_nxt     = s_data;
                    last_nxt     = s_last;
                    cnt_nxt      = CNT_W'(1);
                    bit_nxt      = 3'd0;
                    underrun_nxt = 1'b0;
                    state_nxt    = ST_DATA;
                end
            end

            ST_DATA, ST_PAD: begin
                // An underrun keeps the frame open with no bit offered until the next byte lands.
                if (underrun) begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        byte_nxt     = s_data;
                        last_nxt     = s_last;
                        cnt_nxt      = cnt_inc;
                        underrun_nxt = 1'b0;
                    end
                end else begin
                    tx_valid = 1'b1;
                    tx_bit   = byte_q[bit_idx];
                    crc_d    = byte_q[bit_idx];
                    crc_en   = tx_ready;
                    if (tx_ready) begin
                        bit_nxt = bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            if (state == ST_DATA && !last_q) begin
                                s_ready = 1'b1;
                                if (s_valid) begin
                                    byte_nxt = s_data;
                                    last_nxt = s_last;
                                    cnt_nxt  = cnt_inc;
                                end else begin
                                    underrun_nxt = 1'b1;
                                end
                            end else if (byte_cnt < MIN_CNT) begin
                                state_nxt = ST_PAD;
                                byte_nxt  = 8'h00;
                                cnt_nxt   = cnt_inc;
                            end else begin
                                state_nxt = ST_FCS;
                                fcs_nxt   = 5'd0;
                            end
                        end
                    end
                end
            end

            ST_FCS: begin
                tx_valid = 1'b1;
                tx_bit   = ~crc_q[fcs_sel];
                tx_last  = (fcs_idx == 5'd31);
                if (tx_ready) begin
                    fcs_nxt = fcs_idx + 5'd1;
                    if (fcs_idx == 5'd31) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_crc32_frame_serializer.sv
// Bench for crc32_frame_serializer: two instances (no padding / 60-byte minimum) against a byte-wise CRC model.
module tb_crc32_frame_serializer;
    import crc32_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_last = 1'b0;
    logic       tx_ready = 1'b0;
    logic       sel = 1'b0;

    logic s_ready0, tx_valid0, tx_bit0, tx_last0, crc_init0, crc_en0, crc_d0;
    logic s_ready1, tx_valid1, tx_bit1, tx_last1, crc_init1, crc_en1, crc_d1;
    logic [31:0] crc_q0, crc_q1;
    logic s_ready, tx_valid, tx_bit, tx_last, crc_init, crc_en;

    always #5 clk = ~clk;

    crc32_frame_serializer #(.MIN_BYTES(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .reset(reset), .s_valid(s_valid & ~sel), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready0), .tx_valid(tx_valid0), .tx_bit(tx_bit0), .tx_last(tx_last0),
        .tx_ready(tx_ready & ~sel), .crc_init(crc_init0), .crc_en(crc_en0), .crc_d(crc_d0),
        .crc_q(crc_q0));
    crc32_lfsr u_lfsr0 (.clk(clk), .init(crc_init0), .en(crc_en0), .d(crc_d0), .q(crc_q0));

    crc32_frame_serializer #(.MIN_BYTES(60), .CNT_W(16)) u_dut60 (
        .clk(clk), .reset(reset), .s_valid(s_valid & sel), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready1), .tx_valid(tx_valid1), .tx_bit(tx_bit1), .tx_last(tx_last1),
        .tx_ready(tx_ready & sel), .crc_init(crc_init1), .crc_en(crc_en1), .crc_d(crc_d1),
        .crc_q(crc_q1));
    crc32_lfsr u_lfsr1 (.clk(clk), .init(crc_init1), .en(crc_en1), .d(crc_d1), .q(crc_q1));

    assign s_ready  = sel ? s_ready1  : s_ready0;
    assign tx_valid = sel ? tx_valid1 : tx_valid0;
    assign tx_bit   = sel ? tx_bit1   : tx_bit0;
    assign tx_last  = sel ? tx_last1  : tx_last0;
    assign crc_init = sel ? crc_init1 : crc_init0;
    assign crc_en   = sel ? crc_en1   : crc_en0;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] stim_q[$];
    bit         stim_last_q[$];
    logic [7:0] frame_buf[$];
    bit         rx_q[$];
    bit         exp_q[$];
    int         last_pos[$];
    int         exp_last[$];
    int         gaps[$];
    int         gap_inits[$];
    int         en_viol;
    bit         timed_out;

    function automatic void clear_stim();
        stim_q.delete();
        stim_last_q.delete();
    endfunction

    function automatic void push_frame(input int len);
        for (int i = 0; i < len; i++) begin
            stim_q.push_back(8'($urandom));
            stim_last_q.push_back(i == len - 1);
        end
    endfunction

    // Reflected byte-wise CRC-32 of frame_buf, final complement applied.
    function automatic logic [31:0] crc32_ref();
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (frame_buf[i]) begin
            c = c ^ {24'h0, frame_buf[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Expected line bits for the stimulus: padded bytes LSB-first, then CRC bits LSB-first.
    function automatic void build_expected(input int min_bytes);
        logic [31:0] c;
        exp_q.delete();
        exp_last.delete();
        frame_buf.delete();
        foreach (stim_q[i]) begin
            frame_buf.push_back(stim_q[i]);
            if (stim_last_q[i]) begin
                while (frame_buf.size() < min_bytes) frame_buf.push_back(8'h00);
                foreach (frame_buf[j])
                    for (int b = 0; b < 8; b++) exp_q.push_back(frame_buf[j][b]);
                c = crc32_ref();
                for (int k = 0; k < 32; k++) exp_q.push_back(c[k]);
                exp_last.push_back(exp_q.size() - 1);
                frame_buf.delete();
            end
        end
    endfunction

    function automatic int first_diff();
        int n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (rx_q[i] !== exp_q[i]) return i;
        if (rx_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic logic [31:0] rx_word(input int start);
        logic [31:0] w = '0;
        for (int k = 0; k < 32; k++)
            if (start + k < rx_q.size()) w[k] = rx_q[start + k];
        return w;
    endfunction

    // Receiver-side serial CRC over received bits [0, n).
    function automatic logic [31:0] rx_residue(input int n);
        logic [31:0] q = CRC32_INIT;
        for (int i = 0; i < n && i < rx_q.size(); i++)
            q = {q[30:0], 1'b0} ^ ({32{q[31] ^ rx_q[i]}} & CRC32_POLY);
        return q;
    endfunction

    task automatic run_stream(input int ready_pct, input int valid_pct, input int nframes);
        int bi = 0, seen = 0, cyc = 0, gap = 0, gap_i = 0;
        bit in_gap = 0;
        rx_q.delete(); last_pos.delete(); gaps.delete(); gap_inits.delete();
        en_viol = 0; timed_out = 0;
        while (seen < nframes) begin
            @(negedge clk);
            tx_ready = ($urandom_range(99) < ready_pct);
            s_valid  = (bi < stim_q.size()) && ($urandom_range(99) < valid_pct);
            s_data   = (bi < stim_q.size()) ? stim_q[bi] : 8'($urandom);
            s_last   = (bi < stim_q.size()) ? stim_last_q[bi] : 1'($urandom);
            #1;
            if (crc_en && !tx_ready) en_viol++;
            if (in_gap) begin
                if (tx_valid) begin
                    gaps.push_back(gap); gap_inits.push_back(gap_i); in_gap = 0;
                end else begin
                    gap++; if (crc_init) gap_i++;
                end
            end
            if (tx_valid && tx_ready) begin
                rx_q.push_back(tx_bit);
                if (tx_last) begin
                    last_pos.push_back(rx_q.size() - 1);
                    seen++; in_gap = (seen < nframes); gap = 0; gap_i = 0;
                end
            end
            if (s_valid && s_ready) bi++;
            cyc++;
            if (cyc > 20000) begin timed_out = 1; break; end
        end
        @(negedge clk);
        s_valid = 0; tx_ready = 1;
    endtask

    task automatic test_reset();
        reset = 1; sel = 0;
        repeat (3) @(posedge clk);
        for (int s = 0; s < 2; s++) begin
            @(negedge clk); sel = 1'(s); #1;
            vectors++;
            if ({tx_valid, tx_last, s_ready, crc_init, crc_en} !== 5'b00110) begin
                errors++;
                $display("FAIL reset[%0d]: {valid,last,ready,init,en} got %b exp 00110", s,
                         {tx_valid, tx_last, s_ready, crc_init, crc_en});
            end
        end
        @(negedge clk); reset = 0; sel = 0;
    endtask

    task automatic test_zero_byte();
        int d;
        sel = 0; clear_stim();
        stim_q.push_back(8'h00); stim_last_q.push_back(1);
        build_expected(0);
        run_stream(100, 100, 1);
        d = first_diff();
        vectors++;
        if (timed_out || d != -1) begin
            errors++; $display("FAIL zero_byte bits: first diff at %0d (got %0d bits, exp %0d), timeout %0b",
                               d, rx_q.size(), exp_q.size(), timed_out);
        end
        vectors++;
        if (rx_word(8) !== 32'hD202EF8D) begin
            errors++; $display("FAIL zero_byte fcs: got %h exp d202ef8d", rx_word(8));
        end
        vectors++;
        if (last_pos.size() != 1 || last_pos[0] != 39) begin
            errors++; $display("FAIL zero_byte tx_last: got pos %0d exp 39", last_pos.size() ? last_pos[0] : -1);
        end
    endtask

    function automatic void load_check_string();
        string s = "123456789";
        clear_stim();
        for (int i = 0; i < 9; i++) begin
            stim_q.push_back(s[i]); stim_last_q.push_back(i == 8);
        end
    endfunction

    task automatic test_check_string(input int ready_pct);
        int d;
        sel = 0; load_check_string();
        build_expected(0);
        run_stream(ready_pct, 100, 1);
        d = first_diff();
        vectors++;
        if (timed_out || d != -1) begin
            errors++; $display("FAIL check_string(rdy %0d) bits: first diff at %0d (got %0d bits, exp %0d)",
                               ready_pct, d, rx_q.size(), exp_q.size());
        end
        vectors++;
        if (rx_word(72) !== 32'hCBF43926) begin
            errors++; $display("FAIL check_string(rdy %0d) fcs: got %h exp cbf43926", ready_pct, rx_word(72));
        end
        vectors++;
        if (rx_residue(104) !== CRC32_RESIDUE) begin
            errors++; $display("FAIL check_string(rdy %0d) residue: got %h exp c704dd7b", ready_pct, rx_residue(104));
        end
        vectors++;
        if (en_viol != 0) begin
            errors++; $display("FAIL check_string(rdy %0d) crc_en while stalled: got %0d cycles exp 0", ready_pct, en_viol);
        end
    endtask

    task automatic test_pad();
        int d, ones = 0;
        sel = 1; clear_stim();
        stim_q.push_back(8'hA5); stim_last_q.push_back(1);
        build_expected(60);
        run_stream(100, 100, 1);
        d = first_diff();
        vectors++;
        if (timed_out || d != -1) begin
            errors++; $display("FAIL pad bits: first diff at %0d (got %0d bits, exp %0d)", d, rx_q.size(), exp_q.size());
        end
        for (int i = 8; i < 480 && i < rx_q.size(); i++) ones += rx_q[i];
        vectors++;
        if (rx_word(0)[7:0] !== 8'hA5 || ones != 0) begin
            errors++; $display("FAIL pad layout: first byte %h exp a5, ones in pad %0d exp 0", rx_word(0)[7:0], ones);
        end
        vectors++;
        if (last_pos.size() != 1 || last_pos[0] != 511) begin
            errors++; $display("FAIL pad tx_last: got pos %0d exp 511", last_pos.size() ? last_pos[0] : -1);
        end
        sel = 0;
    endtask

    task automatic test_back_to_back();
        int d;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s); clear_stim();
            push_frame($urandom_range(1, 6)); push_frame($urandom_range(1, 6));
            build_expected(s ? 60 : 0);
            run_stream(100, 100, 2);
            d = first_diff();
            vectors++;
            if (timed_out || d != -1) begin
                errors++; $display("FAIL back_to_back[%0d] bits: first diff at %0d (got %0d, exp %0d)",
                                   s, d, rx_q.size(), exp_q.size());
            end
            vectors++;
            if (gaps.size() != 1 || gaps[0] != 1 || gap_inits[0] != 1) begin
                errors++; $display("FAIL back_to_back[%0d] gap: got %0d idle / %0d init cycles exp 1/1", s,
                                   gaps.size() ? gaps[0] : -1, gap_inits.size() ? gap_inits[0] : -1);
            end
        end
        sel = 0;
    endtask

    task automatic test_random();
        int d;
        for (int r = 0; r < 6; r++) begin
            sel = 1'(r >= 4); clear_stim();
            for (int f = 0; f < (sel ? 1 : 3); f++) push_frame($urandom_range(1, 8));
            build_expected(sel ? 60 : 0);
            run_stream(50, 60, sel ? 1 : 3);
            d = first_diff();
            vectors++;
            if (timed_out || d != -1 || last_pos.size() != exp_last.size()) begin
                errors++; $display("FAIL random[%0d] bits: first diff at %0d (got %0d, exp %0d), frames %0d/%0d",
                                   r, d, rx_q.size(), exp_q.size(), last_pos.size(), exp_last.size());
            end
            vectors++;
            if (en_viol != 0) begin
                errors++; $display("FAIL random[%0d] crc_en while stalled: got %0d exp 0", r, en_viol);
            end
        end
        sel = 0;
    endtask

    task automatic test_reset_in_fcs();
        int cnt = 0, cyc = 0, bi = 0, d;
        bit saw_last = 0, hit = 0;
        sel = 0; clear_stim(); push_frame(3);
        while (!hit && cyc < 2000) begin
            @(negedge clk);
            tx_ready = 1;
            s_valid  = (bi < stim_q.size());
            if (s_valid) begin s_data = stim_q[bi]; s_last = stim_last_q[bi]; end
            #1;
            if (tx_valid && tx_last) saw_last = 1;
            if (tx_valid && cnt == 34) begin
                reset = 1; s_valid = 0; hit = 1;
            end else begin
                if (tx_valid) cnt++;
                if (s_valid && s_ready) bi++;
            end
            cyc++;
        end
        @(negedge clk); #1;
        vectors++;
        if (!hit || {tx_valid, s_ready, crc_init} !== 3'b011 || saw_last) begin
            errors++; $display("FAIL reset_in_fcs: hit %0b {valid,ready,init} got %b exp 011, early tx_last %0b",
                               hit, {tx_valid, s_ready, crc_init}, saw_last);
        end
        reset = 0;
        clear_stim(); push_frame($urandom_range(1, 5));
        build_expected(0);
        run_stream(100, 100, 1);
        d = first_diff();
        vectors++;
        if (timed_out || d != -1) begin
            errors++; $display("FAIL reset_in_fcs next frame: first diff at %0d (got %0d, exp %0d)",
                               d, rx_q.size(), exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_zero_byte();
        test_check_string(100);
        test_check_string(50);
        test_pad();
        test_back_to_back();
        test_random();
        test_reset_in_fcs();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
